// File: rtl/reg_file_pkg.sv
// Shared constants for the configuration/status register file: register map,
// reset values and the default read-only mask.
package reg_file_pkg;

    // Register map of the exported configuration window
    localparam int REG_ALU_OPA   = 0;
    localparam int REG_ALU_OPB   = 1;
    localparam int REG_UART_CFG  = 2;
    localparam int REG_DIV_RATIO = 3;

    // UART: parity enable, even parity. Divider: prescale of 32.
    localparam logic [7:0]  DEF_RST_VAL2 = 8'b1000_0001;
    localparam logic [7:0]  DEF_RST_VAL3 = 8'b0010_0000;
    localparam logic [15:0] DEF_RO_MASK  = 16'h0000;

    // Reset value of register idx; everything outside the UART/divider slots clears to zero.
    function automatic logic [7:0] default_reset_value(input int idx);
        logic [7:0] val;
        val = 8'h00;
        if (idx == REG_UART_CFG)  val = DEF_RST_VAL2;
        if (idx == REG_DIV_RATIO) val = DEF_RST_VAL3;
        return val;
    endfunction

endpackage

// File: rtl/reg_file_cfg.sv
// Parametrised config/status register file with a bus port (1-cycle registered reads),
// a hardware status-write port that bypasses write protection, and a flat export of the low registers.
module reg_file_cfg
    import reg_file_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int ADDRESS_WIDTH = 4,
    parameter int NUM_EXPORT    = 4,
    parameter logic [2**ADDRESS_WIDTH-1:0] RO_MASK  = (2**ADDRESS_WIDTH)'(DEF_RO_MASK),
    parameter logic [WIDTH-1:0]            RST_VAL2 = WIDTH'(DEF_RST_VAL2),
    parameter logic [WIDTH-1:0]            RST_VAL3 = WIDTH'(DEF_RST_VAL3)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          WrEn,
    input  logic                          RdEn,
    input  logic [ADDRESS_WIDTH-1:0]      Address,
    input  logic [WIDTH-1:0]              WrData,
    input  logic                          HwWrEn,
    input  logic [ADDRESS_WIDTH-1:0]      HwAddress,
    input  logic [WIDTH-1:0]              HwWrData,
    output logic [WIDTH-1:0]              RdData,
    output logic                          RdData_Valid,
    output logic                          AddrErr,
    output logic                          WrProtErr,
    output logic [NUM_EXPORT*WIDTH-1:0]   REG_EXPORT
);

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            bus_sel;
    logic [DEPTH-1:0]            hw_sel;
    logic [DEPTH-1:0]            ro_vec;
    logic [WIDTH-1:0]            rd_mux;
    logic                        addr_ok;
    logic                        rd_fire;
    logic                        wr_prot;

    assign addr_ok = (int'(Address) < DEPTH);
    // A simultaneous write wins over the read, which is dropped.
    assign rd_fire = RdEn & ~WrEn;

    for (genvar i = 0; i < DEPTH; i++) begin : gen_reg
        localparam logic [WIDTH-1:0] RV = (i == REG_UART_CFG)  ? RST_VAL2 :
                                          (i == REG_DIV_RATIO) ? RST_VAL3 : '0;
        logic [WIDTH-1:0] q;

        assign bus_sel[i] = WrEn   && (Address   == ADDRESS_WIDTH'(i));
        assign hw_sel[i]  = HwWrEn && (HwAddress == ADDRESS_WIDTH'(i));
        assign ro_vec[i]  = RO_MASK[i];

        // An accepted bus write beats the hardware port; a rejected one lets hardware data through.
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                q <= RV;
            end else if (bus_sel[i] && !ro_vec[i]) begin
                q <= WrData;
            end else if (hw_sel[i]) begin
                q <= HwWrData;
            end
        end

        assign regs[i] = q;
    end

    // Out-of-range addresses match no register and read back as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (Address == ADDRESS_WIDTH'(i)) begin
                rd_mux = regs[i];
            end
        end
    end

    assign wr_prot = |(bus_sel & ro_vec);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RdData       <= '0;
            RdData_Valid <= 1'b0;
            AddrErr      <= 1'b0;
            WrProtErr    <= 1'b0;
        end else begin
            RdData_Valid <= rd_fire;
            if (rd_fire) begin
                RdData <= rd_mux;
            end
            AddrErr   <= (WrEn | RdEn) & ~addr_ok;
            WrProtErr <= wr_prot;
        end
    end

    for (genvar i = 0; i < NUM_EXPORT; i++) begin : gen_export
        assign REG_EXPORT[i*WIDTH +: WIDTH] = regs[i];
    end

endmodule

// File: tb/tb_reg_file_cfg.sv
// Bench for reg_file_cfg (DEPTH=12, register 8 read-only): vector table plus reset-during-read sequence.
module tb_reg_file_cfg;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        WrEn = 1'b0, RdEn = 1'b0, HwWrEn = 1'b0;
    logic [3:0]  Address = '0, HwAddress = '0;
    logic [7:0]  WrData = '0, HwWrData = '0;
    logic [7:0]  RdData;
    logic        RdData_Valid, AddrErr, WrProtErr;
    logic [31:0] REG_EXPORT;

    int checks   = 0;
    int failures = 0;
    logic [7:0] rd_q[$];
    logic [7:0] last_rd;

    reg_file_cfg #(
        .WIDTH(8), .DEPTH(12), .ADDRESS_WIDTH(4), .NUM_EXPORT(4),
        .RO_MASK(16'h0100), .RST_VAL2(8'h81), .RST_VAL3(8'h20)
    ) dut (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .HwWrEn(HwWrEn), .HwAddress(HwAddress), .HwWrData(HwWrData),
        .RdData(RdData), .RdData_Valid(RdData_Valid), .AddrErr(AddrErr),
        .WrProtErr(WrProtErr), .REG_EXPORT(REG_EXPORT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we, re;
        logic [3:0]  addr;
        logic [7:0]  wd;
        logic        hwe;
        logic [3:0]  hwaddr;
        logic [7:0]  hwd;
        logic        exp_vld;
        logic [7:0]  exp_rd;
        logic        exp_ae, exp_pe;
        logic [31:0] exp_export;
    } vec_t;

    vec_t vt[21];

    function automatic vec_t mk(logic we, logic re, logic [3:0] addr, logic [7:0] wd,
                                logic hwe, logic [3:0] hwaddr, logic [7:0] hwd,
                                logic vld, logic [7:0] rd, logic ae, logic pe, logic [31:0] ex);
        vec_t v;
        v.we = we; v.re = re; v.addr = addr; v.wd = wd;
        v.hwe = hwe; v.hwaddr = hwaddr; v.hwd = hwd;
        v.exp_vld = vld; v.exp_rd = rd; v.exp_ae = ae; v.exp_pe = pe; v.exp_export = ex;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Compares the read channel against the scoreboard, then the flags and export bus.
    task automatic check_outputs(input string tag, input logic exp_vld, input logic exp_ae,
                                 input logic exp_pe, input logic [31:0] exp_export);
        chk({tag, "_valid"}, 32'(RdData_Valid), 32'(exp_vld));
        if (RdData_Valid === 1'b1) begin
            if (rd_q.size() == 0) begin
                chk({tag, "_unexpected_read"}, 32'(1), 32'(0));
            end else begin
                last_rd = rd_q.pop_front();
                chk({tag, "_rddata"}, 32'(RdData), 32'(last_rd));
            end
        end else begin
            chk({tag, "_rdhold"}, 32'(RdData), 32'(last_rd));
        end
        chk({tag, "_addrerr"}, 32'(AddrErr), 32'(exp_ae));
        chk({tag, "_wrproterr"}, 32'(WrProtErr), 32'(exp_pe));
        chk({tag, "_export"}, REG_EXPORT, exp_export);
    endtask

    initial begin
        //                 we  re  addr   wd    hwe hwaddr hwd   vld rd     ae  pe  export
        vt[0]  = mk(1, 0, 4'd0,  8'h02, 0, 4'd0,  8'h00, 0, 8'h00, 0, 0, 32'h2081_0002);
        vt[1]  = mk(0, 1, 4'd0,  8'h00, 0, 4'd0,  8'h00, 1, 8'h02, 0, 0, 32'h2081_0002);
        vt[2]  = mk(0, 1, 4'd3,  8'h00, 0, 4'd0,  8'h00, 1, 8'h20, 0, 0, 32'h2081_0002);
        vt[3]  = mk(0, 1, 4'd2,  8'h00, 0, 4'd0,  8'h00, 1, 8'h81, 0, 0, 32'h2081_0002);
        vt[4]  = mk(1, 0, 4'd8,  8'hAA, 0, 4'd0,  8'h00, 0, 8'h00, 0, 1, 32'h2081_0002);
        vt[5]  = mk(0, 1, 4'd8,  8'h00, 0, 4'd0,  8'h00, 1, 8'h00, 0, 0, 32'h2081_0002);
        vt[6]  = mk(0, 0, 4'd0,  8'h00, 1, 4'd8,  8'h55, 0, 8'h00, 0, 0, 32'h2081_0002);
        vt[7]  = mk(0, 1, 4'd8,  8'h00, 0, 4'd0,  8'h00, 1, 8'h55, 0, 0, 32'h2081_0002);
        vt[8]  = mk(0, 1, 4'd13, 8'h00, 0, 4'd0,  8'h00, 1, 8'h00, 1, 0, 32'h2081_0002);
        vt[9]  = mk(1, 0, 4'd14, 8'h77, 0, 4'd0,  8'h00, 0, 8'h00, 1, 0, 32'h2081_0002);
        vt[10] = mk(1, 0, 4'd5,  8'h11, 1, 4'd5,  8'h22, 0, 8'h00, 0, 0, 32'h2081_0002);
        vt[11] = mk(0, 1, 4'd5,  8'h00, 0, 4'd0,  8'h00, 1, 8'h11, 0, 0, 32'h2081_0002);
        vt[12] = mk(1, 1, 4'd6,  8'h33, 0, 4'd0,  8'h00, 0, 8'h00, 0, 0, 32'h2081_0002);
        vt[13] = mk(0, 1, 4'd6,  8'h00, 0, 4'd0,  8'h00, 1, 8'h33, 0, 0, 32'h2081_0002);
        vt[14] = mk(1, 0, 4'd8,  8'hCC, 1, 4'd8,  8'h77, 0, 8'h00, 0, 1, 32'h2081_0002);
        vt[15] = mk(0, 1, 4'd8,  8'h00, 0, 4'd0,  8'h00, 1, 8'h77, 0, 0, 32'h2081_0002);
        vt[16] = mk(0, 0, 4'd0,  8'h00, 1, 4'd12, 8'h99, 0, 8'h00, 0, 0, 32'h2081_0002);
        vt[17] = mk(1, 0, 4'd1,  8'h5A, 0, 4'd0,  8'h00, 0, 8'h00, 0, 0, 32'h2081_5A02);
        vt[18] = mk(0, 0, 4'd0,  8'h00, 1, 4'd3,  8'h40, 0, 8'h00, 0, 0, 32'h4081_5A02);
        vt[19] = mk(0, 1, 4'd3,  8'h00, 0, 4'd0,  8'h00, 1, 8'h40, 0, 0, 32'h4081_5A02);
        vt[20] = mk(0, 0, 4'd0,  8'h00, 0, 4'd0,  8'h00, 0, 8'h00, 0, 0, 32'h4081_5A02);

        last_rd = 8'h00;
        repeat (3) tick();
        check_outputs("reset", 1'b0, 1'b0, 1'b0, 32'h2081_0000);
        RST = 1'b1;
        tick();
        check_outputs("post_reset", 1'b0, 1'b0, 1'b0, 32'h2081_0000);

        for (int i = 0; i < 21; i++) begin
            WrEn = vt[i].we;   RdEn = vt[i].re;    Address = vt[i].addr;  WrData = vt[i].wd;
            HwWrEn = vt[i].hwe; HwAddress = vt[i].hwaddr; HwWrData = vt[i].hwd;
            if (vt[i].exp_vld) rd_q.push_back(vt[i].exp_rd);
            tick();
            check_outputs($sformatf("vec%0d", i), vt[i].exp_vld, vt[i].exp_ae,
                          vt[i].exp_pe, vt[i].exp_export);
        end
        chk("queue_drained_table", 32'(rd_q.size()), 32'(0));

        // Reset arriving between edges while a read stream is in progress
        WrEn = 1'b0; HwWrEn = 1'b0; RdEn = 1'b1; Address = 4'd3;
        rd_q.push_back(8'h40);
        tick();
        check_outputs("pre_rst_read", 1'b1, 1'b0, 1'b0, 32'h4081_5A02);
        #2;
        RST = 1'b0;
        rd_q.delete();
        last_rd = 8'h00;
        #1;
        chk("midrst_valid", 32'(RdData_Valid), 32'(0));
        chk("midrst_rddata", 32'(RdData), 32'(0));
        chk("midrst_export", REG_EXPORT, 32'h2081_0000);
        RdEn = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        check_outputs("after_rst", 1'b0, 1'b0, 1'b0, 32'h2081_0000);

        RdEn = 1'b1; Address = 4'd3;
        rd_q.push_back(8'h20);
        tick();
        check_outputs("reg3_reset_val", 1'b1, 1'b0, 1'b0, 32'h2081_0000);
        Address = 4'd8;
        rd_q.push_back(8'h00);
        tick();
        check_outputs("reg8_reset_val", 1'b1, 1'b0, 1'b0, 32'h2081_0000);
        RdEn = 1'b0;
        tick();
        check_outputs("final_idle", 1'b0, 1'b0, 1'b0, 32'h2081_0000);
        chk("queue_drained_end", 32'(rd_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
